// File: rtl/reg_write_arbiter.sv
// Arbitrated single-writer front end for a shared q/qn data register.
// Define REG_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest index wins.
module reg_write_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WIDTH-1:0]     wdata,
  output logic [N_REQ-1:0]           gnt,
  output logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           qn,
  output logic                       done,
  output logic [$clog2(N_REQ)-1:0]   last_id,
  output logic                       busy
);

  localparam int IDW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [IDW-1:0]     win_r, win_s;
  logic [IDW-1:0]     last_r, last_s;
  logic [N_REQ-1:0]   gnt_r, gnt_s;
  logic [WIDTH-1:0]   q_r, q_s;
  logic [WIDTH-1:0]   qn_r, qn_s;
  logic [WIDTH-1:0]   slice_s;
  logic               done_r;
  logic               busy_r;

`ifdef REG_ARB_ROUND_ROBIN_EN
  logic [IDW-1:0]     ptr_r, ptr_s;

  // Search starts just after the previous winner; scanning backwards leaves the nearest hit in w.
  function automatic logic [IDW-1:0] arbitrate(input logic [N_REQ-1:0] r, input logic [IDW-1:0] ptr);
    logic [IDW-1:0] w;
    logic [IDW-1:0] idx;
    int             c;
    w = {IDW{1'b0}};
    for (int k = N_REQ; k >= 1; k--) begin
      c   = (int'(ptr) + k) % N_REQ;
      idx = IDW'(c);
      if (r[idx]) begin
        w = idx;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction
`else
  function automatic logic [IDW-1:0] arbitrate(input logic [N_REQ-1:0] r);
    logic [IDW-1:0] w;
    logic [IDW-1:0] idx;
    w = {IDW{1'b0}};
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = IDW'(k);
      if (r[idx]) begin
        w = idx;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction
`endif

  assign slice_s = WIDTH'(wdata >> (int'(win_r) * WIDTH));

  // Next-state, arbitration and commit datapath.
  always_comb begin
    state_s = state_r;
    win_s   = win_r;
    last_s  = last_r;
    gnt_s   = {N_REQ{1'b0}};
    q_s     = q_r;
    qn_s    = qn_r;
`ifdef REG_ARB_ROUND_ROBIN_EN
    ptr_s   = ptr_r;
`endif
    case (state_r)
      IDLE, COMMIT: begin
        if (req != {N_REQ{1'b0}}) begin
`ifdef REG_ARB_ROUND_ROBIN_EN
          win_s = arbitrate(req, ptr_r);
`else
          win_s = arbitrate(req);
`endif
          gnt_s   = {{(N_REQ-1){1'b0}}, 1'b1} << win_s;
          state_s = GRANT;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        q_s     = slice_s;
        qn_s    = ~slice_s;
        last_s  = win_r;
`ifdef REG_ARB_ROUND_ROBIN_EN
        ptr_s   = win_r;
`endif
        state_s = COMMIT;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; done and busy are registered from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      win_r   <= {IDW{1'b0}};
      last_r  <= {IDW{1'b0}};
      gnt_r   <= {N_REQ{1'b0}};
      q_r     <= {WIDTH{1'b0}};
      qn_r    <= {WIDTH{1'b1}};
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
`ifdef REG_ARB_ROUND_ROBIN_EN
      ptr_r   <= IDW'(N_REQ - 1);
`endif
    end else begin
      state_r <= state_s;
      win_r   <= win_s;
      last_r  <= last_s;
      gnt_r   <= gnt_s;
      q_r     <= q_s;
      qn_r    <= qn_s;
      done_r  <= (state_s == COMMIT);
      busy_r  <= (state_s != IDLE);
`ifdef REG_ARB_ROUND_ROBIN_EN
      ptr_r   <= ptr_s;
`endif
    end
  end

  assign gnt     = gnt_r;
  assign q       = q_r;
  assign qn      = qn_r;
  assign done    = done_r;
  assign last_id = last_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: random requesters obeying the handshake, a transaction
// model that predicts each grant and commit, and a monitor that checks outputs every cycle.
module tb_reg_write_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int P_IDLE   = 0;
  localparam int P_GRANT  = 1;
  localparam int P_COMMIT = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N*W-1:0] wdata;
  logic [N-1:0] gnt;
  logic [W-1:0] q, qn;
  logic         done;
  logic [1:0]   last_id;
  logic         busy;

  reg_write_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata), .gnt(gnt),
    .q(q), .qn(qn), .done(done), .last_id(last_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct { int id; logic [7:0] d; } txn_t;
  txn_t gq[$];
  txn_t cq[$];
  int         m_phase;
  int         m_ptr;
  logic [7:0] m_q;
  int         m_last;

  // Winner by the arbitration rule, or -1 when nobody requests.
  function automatic int pick(input logic [N-1:0] r, input int ptr);
`ifdef REG_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (ptr + k) % N;
      if (((r >> c) & 4'b0001) != 4'b0000) return c;
    end
`else
    for (int c = 0; c < N; c++) begin
      if (((r >> c) & 4'b0001) != 4'b0000) return c;
    end
`endif
    return -1;
  endfunction

  // Reference model: decides arbitrations and queues the expected grant and commit.
  always @(posedge clk) begin
    int   w;
    txn_t t;
    if (!reset) begin
      m_phase = P_IDLE;
      m_ptr   = N - 1;
      gq.delete();
      cq.delete();
      m_q     = 8'h00;
      m_last  = 0;
    end else if (m_phase == P_GRANT) begin
      m_phase = P_COMMIT;
    end else begin
      w = pick(req, m_ptr);
      if (w >= 0) begin
        t.id = w;
        t.d  = 8'(wdata >> (w * W));
        gq.push_back(t);
        cq.push_back(t);
        m_ptr   = w;
        m_phase = P_GRANT;
      end else begin
        m_phase = P_IDLE;
      end
    end
  end

  // Monitor: pops expectations when the model says a grant or commit is visible.
  always @(negedge clk) begin
    txn_t       t;
    logic [7:0] e;
    if (m_phase == P_GRANT) begin
      if (gq.size() == 0) chk("grant_queue_underflow", 32'd1, 32'd0);
      else begin
        t = gq.pop_front();
        chk("gnt", {28'd0, gnt}, 32'd1 << t.id);
      end
    end else begin
      chk("gnt_zero", {28'd0, gnt}, 32'd0);
    end
    if (m_phase == P_COMMIT) begin
      if (cq.size() == 0) chk("commit_queue_underflow", 32'd1, 32'd0);
      else begin
        t = cq.pop_front();
        m_q    = t.d;
        m_last = t.id;
      end
      chk("done_pulse", {31'd0, done}, 32'd1);
    end else begin
      chk("done_low", {31'd0, done}, 32'd0);
    end
    e = ~m_q;
    chk("q", {24'd0, q}, {24'd0, m_q});
    chk("qn", {24'd0, qn}, {24'd0, e});
    chk("last_id", {30'd0, last_id}, m_last);
    chk("busy", {31'd0, busy}, (m_phase != P_IDLE) ? 32'd1 : 32'd0);
  end

  logic [N-1:0] persist;
  logic [N-1:0] drop_p;
  int           rate;

  task automatic set_data(input int i, input logic [7:0] d);
    wdata = (wdata & ~(32'hFF << (i * W))) | (32'(d) << (i * W));
  endtask

  // One clock of requester behaviour: hold until granted, drop on the edge ending GRANT.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (drop_p[i]) begin
        drop_p[i] = 1'b0;
        if (persist[i]) set_data(i, 8'($urandom));
        else req[i] = 1'b0;
      end else if (gnt[i]) begin
        drop_p[i] = 1'b1;
      end else if (!req[i] && rate > 0 && $urandom_range(99) < rate) begin
        req[i] = 1'b1;
        set_data(i, 8'($urandom));
      end
    end
  endtask

  task automatic drain();
    persist = 4'b0000;
    rate    = 0;
    for (int k = 0; k < 60 && (req != 4'b0000 || busy); k++) step();
    if (req != 4'b0000 || busy) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    reset   = 1'b0;
    req     = 4'b1111;
    wdata   = 32'h4433_2211;
    persist = 4'b0000;
    drop_p  = 4'b0000;
    rate    = 0;
    repeat (4) step();
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_q", {24'd0, q}, 32'h00);
    chk("rst_qn", {24'd0, qn}, 32'hFF);
    req   = 4'b0000;
    reset = 1'b1;
    step();

    req = 4'b0100;
    set_data(2, 8'hA5);
    step();
    chk("single_gnt", {28'd0, gnt}, 32'h4);
    step();
    chk("single_q", {24'd0, q}, 32'hA5);
    chk("single_qn", {24'd0, qn}, 32'h5A);
    chk("single_last", {30'd0, last_id}, 32'd2);
    chk("single_done", {31'd0, done}, 32'd1);
    drain();

    req     = 4'b1111;
    persist = 4'b1111;
    wdata   = 32'hD4C3_B2A1;
    repeat (20) step();
    drain();

    req     = 4'b1010;
    persist = 4'b1010;
    repeat (20) step();
    drain();

    req = 4'b1000;
    set_data(3, 8'h3C);
    step();
    reset  = 1'b0;
    req    = 4'b0000;
    drop_p = 4'b0000;
    step();
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_q", {24'd0, q}, 32'h00);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    step();

    req     = 4'b1000;
    persist = 4'b1000;
    set_data(3, 8'h77);
    step();
    req[0]  = 1'b1;
    set_data(0, 8'h99);
    persist = 4'b1001;
    repeat (8) step();
    drain();

    rate = 35;
    repeat (500) step();
    drain();
    repeat (3) step();
    chk("grant_queue_empty", gq.size(), 32'd0);
    chk("commit_queue_empty", cq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
